// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared definitions for the BCD countdown timer:
//   state_t            - 2-bit FSM encoding (IDLE, RUN, PAUSE, DONE)
//   UNITS_MAX/TENS_MAX - wrap values for the BCD digits of a mm:ss count
//   ALARM_LEN_DEFAULT  - default number of cycles the alarm is held
//   bcd_pair_ok()      - legality check of one two-digit BCD preset
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  localparam int unsigned ALARM_LEN_DEFAULT = 10;

  // A minutes or seconds byte is legal when units <= 9 and tens <= 5.
  function automatic logic bcd_pair_ok(input logic [7:0] value);
    return (value[3:0] <= UNITS_MAX) && (value[7:4] <= TENS_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
// Control/status bundle of the countdown timer.
//   Inputs to the timer : load, preset_min, preset_sec, start, pause
//   Outputs of the timer: min_out, sec_out, running, done, alarm, load_err,
//                         state (debug view of the FSM)
// Control semantics: there is no valid/ready pair. Every control input is a
// level sampled on each rising clk_cin edge, with priority load > pause >
// start; every output is registered and changes only after the edge that
// causes it (or immediately on rst).
// Modports: master drives the controls (testbench/parent), slave is the timer.
interface countdown_timer_if;
  import countdown_pkg::*;

  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;

  logic [7:0] min_out;
  logic [7:0] sec_out;
  logic       running;
  logic       done;
  logic       alarm;
  logic       load_err;
  state_t     state;

  modport master (
    output load, preset_min, preset_sec, start, pause,
    input  min_out, sec_out, running, done, alarm, load_err, state
  );

  modport slave (
    input  load, preset_min, preset_sec, start, pause,
    output min_out, sec_out, running, done, alarm, load_err, state
  );

endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit
// One BCD digit of a down-counter chain.
//   clk_cin - count clock
//   rst     - asynchronous, active-high reset (digit -> 0)
//   en      - decrement this digit on the next edge
//   load    - synchronous load of preset (wins over en)
//   preset  - value to load
//   digit   - registered digit value
//   borrow  - combinational: this digit is enabled and sits at 0, so it wraps
//             to MAX and the next more significant digit must decrement
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk_cin,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] preset,
  output logic [3:0] digit,
  output logic       borrow
);

  assign borrow = en && (digit == 4'd0);

  always_ff @(posedge clk_cin or posedge rst) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= preset;
    end else if (en) begin
      digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
// mm:ss BCD countdown timer with load/start/pause control and a timed alarm.
//   clk_cin - count clock, one rising edge per second
//   rst     - asynchronous, active-high reset
//   bus     - countdown_timer_if.slave:
//     load/preset_min/preset_sec - load a BCD preset, forces IDLE; an
//                                  illegal digit keeps the old count and
//                                  pulses load_err for one cycle
//     start  - IDLE->RUN (count != 0), PAUSE->RUN, DONE->IDLE
//     pause  - RUN->PAUSE
//     min_out/sec_out - current count (registered BCD)
//     running/done    - state is RUN / state is DONE
//     alarm           - high for ALARM_LEN cycles after entering DONE
//     state           - FSM state for observation
// The count lives in four bcd_down_digit instances chained by borrow; this
// level holds the FSM, preset validation, zero detection and alarm counter.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned ALARM_LEN = ALARM_LEN_DEFAULT
) (
  input logic               clk_cin,
  input logic               rst,
  countdown_timer_if.slave  bus
);

  localparam logic [7:0] ALARM_LEN_8 = 8'(ALARM_LEN);

  state_t     state;
  logic       running_q;
  logic       done_q;
  logic       alarm_q;
  logic       load_err_q;
  logic [7:0] alarm_cnt;

  logic       preset_ok;
  logic       digit_load;
  logic       count_zero;
  logic       count_one;
  logic       dec;

  logic [3:0] sec_units;
  logic [3:0] sec_tens;
  logic [3:0] min_units;
  logic [3:0] min_tens;
  logic       borrow_su;
  logic       borrow_st;
  logic       borrow_mu;
  logic       borrow_mt;

  assign preset_ok  = bcd_pair_ok(bus.preset_min) && bcd_pair_ok(bus.preset_sec);
  assign digit_load = bus.load && preset_ok;

  assign count_zero = (min_tens == 4'd0) && (min_units == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_units == 4'd0);
  assign count_one  = (min_tens == 4'd0) && (min_units == 4'd0) &&
                      (sec_tens == 4'd0) && (sec_units == 4'd1);

  // Decrement only on a plain RUN edge. The zero guard keeps the chain from
  // ever wrapping 00:00 to 59:59.
  assign dec = (state == ST_RUN) && !bus.load && !bus.pause && !count_zero;

  bcd_down_digit #(.MAX(UNITS_MAX)) u_sec_units (
    .clk_cin (clk_cin),
    .rst     (rst),
    .en      (dec),
    .load    (digit_load),
    .preset  (bus.preset_sec[3:0]),
    .digit   (sec_units),
    .borrow  (borrow_su)
  );

  bcd_down_digit #(.MAX(TENS_MAX)) u_sec_tens (
    .clk_cin (clk_cin),
    .rst     (rst),
    .en      (borrow_su),
    .load    (digit_load),
    .preset  (bus.preset_sec[7:4]),
    .digit   (sec_tens),
    .borrow  (borrow_st)
  );

  bcd_down_digit #(.MAX(UNITS_MAX)) u_min_units (
    .clk_cin (clk_cin),
    .rst     (rst),
    .en      (borrow_st),
    .load    (digit_load),
    .preset  (bus.preset_min[3:0]),
    .digit   (min_units),
    .borrow  (borrow_mu)
  );

  // The top digit's borrow has no consumer: the zero guard on dec means it
  // can never be asserted.
  bcd_down_digit #(.MAX(TENS_MAX)) u_min_tens (
    .clk_cin (clk_cin),
    .rst     (rst),
    .en      (borrow_mu),
    .load    (digit_load),
    .preset  (bus.preset_min[7:4]),
    .digit   (min_tens),
    .borrow  (borrow_mt)
  );

  // FSM with registered status outputs. A pause level blocks start in every
  // state, which keeps the load > pause > start priority uniform.
  always_ff @(posedge clk_cin or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      alarm_cnt  <= 8'd0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      if (bus.load) begin
        state      <= ST_IDLE;
        running_q  <= 1'b0;
        done_q     <= 1'b0;
        alarm_q    <= 1'b0;
        alarm_cnt  <= 8'd0;
        load_err_q <= !preset_ok;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!bus.pause && bus.start && !count_zero) begin
              state     <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.pause) begin
              state     <= ST_PAUSE;
              running_q <= 1'b0;
            end else if (count_one) begin
              // This edge also takes the count from 00:01 to 00:00.
              state     <= ST_DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
              alarm_q   <= 1'b1;
              alarm_cnt <= ALARM_LEN_8;
            end
          end
          ST_PAUSE: begin
            if (!bus.pause && bus.start) begin
              state     <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_DONE: begin
            if (!bus.pause && bus.start) begin
              state     <= ST_IDLE;
              done_q    <= 1'b0;
              alarm_q   <= 1'b0;
              alarm_cnt <= 8'd0;
            end else if (alarm_cnt != 8'd0) begin
              // alarm_cnt holds the cycles left including the current one,
              // so alarm drops on the edge that consumes the last of them.
              alarm_cnt <= alarm_cnt - 8'd1;
              alarm_q   <= (alarm_cnt > 8'd1);
            end
          end
          default: begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
            alarm_cnt <= 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.min_out  = {min_tens, min_units};
  assign bus.sec_out  = {sec_tens, sec_units};
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;
  assign bus.load_err = load_err_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Directed scenarios followed by random control traffic. Expected values come
// from a reference model that keeps the count as a plain number of seconds
// and the alarm as a remaining-cycles number.
module tb_countdown_timer;
  import countdown_pkg::*;

  localparam int ALEN = 10;

  logic clk_cin = 1'b0;
  logic rst     = 1'b0;

  countdown_timer_if bus ();

  countdown_timer #(.ALARM_LEN(ALEN)) dut (
    .clk_cin (clk_cin),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_cin = ~clk_cin;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int     m_secs;
  state_t m_state;
  int     m_alarm_left;
  logic   m_load_err;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic byte_legal(input logic [7:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd5);
  endfunction

  task automatic model_reset();
    m_secs       = 0;
    m_state      = ST_IDLE;
    m_alarm_left = 0;
    m_load_err   = 1'b0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(input logic ld, input logic ps, input logic st,
                            input logic [7:0] pm, input logic [7:0] psec);
    m_load_err = 1'b0;
    if (ld) begin
      if (byte_legal(pm) && byte_legal(psec))
        m_secs = bcd2int(pm) * 60 + bcd2int(psec);
      else
        m_load_err = 1'b1;
      m_state      = ST_IDLE;
      m_alarm_left = 0;
    end else if (m_state == ST_RUN) begin
      if (ps) begin
        m_state = ST_PAUSE;
      end else begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_state      = ST_DONE;
          m_alarm_left = ALEN;
        end
      end
    end else if (m_state == ST_IDLE) begin
      if (!ps && st && m_secs != 0) m_state = ST_RUN;
    end else if (m_state == ST_PAUSE) begin
      if (!ps && st) m_state = ST_RUN;
    end else begin
      if (!ps && st) begin
        m_state      = ST_IDLE;
        m_alarm_left = 0;
      end else if (m_alarm_left > 0) begin
        m_alarm_left = m_alarm_left - 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min"},      32'(bus.min_out),  32'(int2bcd(m_secs / 60)));
    chk({tag, ".sec"},      32'(bus.sec_out),  32'(int2bcd(m_secs % 60)));
    chk({tag, ".state"},    32'(bus.state),    32'(m_state));
    chk({tag, ".running"},  32'(bus.running),  32'(m_state == ST_RUN));
    chk({tag, ".done"},     32'(bus.done),     32'(m_state == ST_DONE));
    chk({tag, ".alarm"},    32'(bus.alarm),    32'(m_alarm_left > 0));
    chk({tag, ".load_err"}, 32'(bus.load_err), 32'(m_load_err));
  endtask

  // Drive one edge's inputs, clock it, advance the model, check after the edge.
  task automatic cycle(input string tag, input logic ld, input logic ps,
                       input logic st, input logic [7:0] pm, input logic [7:0] psec);
    bus.load       = ld;
    bus.pause      = ps;
    bus.start      = st;
    bus.preset_min = pm;
    bus.preset_sec = psec;
    @(posedge clk_cin);
    model_edge(ld, ps, st, pm, psec);
    #1;
    check_all(tag);
    bus.load  = 1'b0;
    bus.pause = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic load_val(input string tag, input logic [7:0] pm, input logic [7:0] psec);
    cycle(tag, 1'b1, 1'b0, 1'b0, pm, psec);
  endtask

  task automatic start_pulse(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
  endtask

  initial begin
    int alarm_hi;
    logic [7:0] rpm;
    logic [7:0] rps;

    bus.load       = 1'b0;
    bus.pause      = 1'b0;
    bus.start      = 1'b0;
    bus.preset_min = 8'h00;
    bus.preset_sec = 8'h00;
    model_reset();

    // Reset state, observed before any clock edge
    #1 rst = 1'b1;
    #1 check_all("reset");
    @(negedge clk_cin);
    @(negedge clk_cin);
    rst = 1'b0;

    // 01:00 -> one RUN edge -> 00:59
    load_val("l0100", 8'h01, 8'h00);
    start_pulse("start0100");
    idle("run0100", 1);
    chk("borrow_min", 32'(bus.min_out), 32'h00);
    chk("borrow_sec", 32'(bus.sec_out), 32'h59);

    // 10:00 -> 09:59 borrows through every digit
    load_val("l1000", 8'h10, 8'h00);
    start_pulse("start1000");
    idle("run1000", 1);
    chk("borrow_all", 32'({bus.min_out, bus.sec_out}), 32'h0959);

    // 00:02 -> DONE, alarm exactly ALEN cycles, start -> IDLE
    load_val("l0002", 8'h00, 8'h02);
    start_pulse("start0002");
    idle("run0002", 2);
    chk("expire_done", 32'(bus.done), 32'd1);
    alarm_hi = (bus.alarm === 1'b1) ? 1 : 0;
    for (int i = 0; i < ALEN + 3; i++) begin
      idle("alarm", 1);
      if (bus.alarm === 1'b1) alarm_hi++;
    end
    chk("alarm_len", 32'(alarm_hi), 32'(ALEN));
    start_pulse("ack");
    chk("ack_done", 32'(bus.done), 32'd0);

    // Start with count 00:00 stays in IDLE
    start_pulse("start_zero");

    // Pause at 05:30 for 5 edges, resume, decrement one edge later
    load_val("l0531", 8'h05, 8'h31);
    start_pulse("start0531");
    idle("run0531", 1);
    for (int i = 0; i < 5; i++) cycle("pause", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("pause_hold", 32'({bus.min_out, bus.sec_out}), 32'h0530);
    start_pulse("resume");
    idle("after_resume", 1);
    chk("resume_dec", 32'({bus.min_out, bus.sec_out}), 32'h0529);

    // Illegal preset keeps 12:34 and pulses load_err once
    load_val("l1234", 8'h12, 8'h34);
    load_val("bad_load", 8'h12, 8'h6A);
    chk("bad_err", 32'(bus.load_err), 32'd1);
    idle("bad_after", 1);
    chk("bad_pulse", 32'(bus.load_err), 32'd0);
    load_val("bad_tens", 8'h60, 8'h00);

    // load + pause + start together during RUN: load wins
    load_val("l0100b", 8'h01, 8'h00);
    start_pulse("start0100b");
    idle("run0100b", 2);
    cycle("all3", 1'b1, 1'b1, 1'b1, 8'h59, 8'h59);
    chk("all3_count", 32'({bus.min_out, bus.sec_out}), 32'h5959);

    // Load during DONE and pause+start while paused
    load_val("l0001", 8'h00, 8'h01);
    start_pulse("start0001");
    idle("run0001", 1);
    load_val("load_in_done", 8'h00, 8'h03);
    start_pulse("start0003");
    cycle("pause0003", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    cycle("pause_start", 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    start_pulse("resume0003");
    idle("run0003", 3);

    // Async reset mid-alarm
    load_val("l0001b", 8'h00, 8'h01);
    start_pulse("start0001b");
    idle("run0001b", 3);
    chk("pre_rst_alarm", 32'(bus.alarm), 32'd1);
    @(negedge clk_cin);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk_cin);
    rst = 1'b0;
    start_pulse("start_after_rst");

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      rpm = ($urandom_range(0, 99) < 85) ? 8'h00
            : {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
      rps = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
      cycle("rand",
            ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 25),
            rpm, rps);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter ALARM_LEN, default 10: number of clk_cin cycles that alarm is held high on expiry; legal range 1..255.
REQ-002 clk_cin  input  1  count clock; one rising edge per second of countdown.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  synchronous load of preset_min/preset_sec; forces IDLE.
REQ-005 preset_min  input  8  BCD minutes preset, tens in [7:4], units in [3:0], legal 00..59.
REQ-006 preset_sec  input  8  BCD seconds preset, same encoding, legal 00..59.
REQ-007 start  input  1  start from IDLE, resume from PAUSE, acknowledge in DONE.
REQ-008 pause  input  1  suspend counting while in RUN.
REQ-009 min_out  output  8  current BCD minutes, registered.
REQ-010 sec_out  output  8  current BCD seconds, registered.
REQ-011 running  output  1  high while state is RUN.
REQ-012 done  output  1  high while state is DONE.
REQ-013 alarm  output  1  high for exactly ALARM_LEN cycles after entering DONE.
REQ-014 load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, 2-bit encoded.
REQ-016 Input priority on each edge SHALL be load > pause > start.
REQ-017 A load in any state SHALL go to IDLE and update the count on the same edge, provided every preset digit is legal: units <=9, tens <=5.
REQ-018 A load with any illegal digit SHALL leave the count unchanged, still force IDLE, and pulse load_err for one cycle.
REQ-019 IDLE + start with count != 00:00 SHALL go to RUN; no decrement on that edge.
REQ-019a IDLE + start with count == 00:00 SHALL keep the block in IDLE.
REQ-020 In RUN, each edge without load or pause SHALL decrement the count by one second as a BCD borrow chain.
REQ-020a Borrow chain: sec units 0->9 borrowing from sec tens; sec tens 0->5 borrowing from min units; min units 0->9 borrowing from min tens; min tens 0->5.
REQ-021 The edge that decrements 00:01 to 00:00 SHALL also move the FSM to DONE; the count SHALL never wrap below 00:00.
REQ-022 RUN + pause SHALL go to PAUSE with no decrement on that edge.
REQ-022a PAUSE SHALL hold the count; PAUSE + start SHALL return to RUN, with decrementing resuming on the following edge.
REQ-023 On entry to DONE, alarm SHALL rise on the same edge and stay high for ALARM_LEN edges, then go low, driven by an 8-bit down-counter.
REQ-024 DONE + start SHALL go to IDLE and clear alarm immediately; the count stays 00:00.
REQ-024a DONE + load SHALL behave per REQ-017/REQ-018.
REQ-025 All outputs SHALL be registered; each change appears after the clk_cin edge that causes it, with zero added latency.

Reset
REQ-026 While rst is high, the following SHALL be forced asynchronously: state=IDLE, min_out=8'h00, sec_out=8'h00, running=0, done=0, alarm=0, load_err=0, alarm counter=0.
REQ-027 Reset asserted mid-RUN or mid-alarm SHALL abort immediately; after release, the block waits for load/start.

Structure
REQ-028 Package countdown_pkg SHALL hold the state encoding, the digit maxima (UNITS_MAX=9, TENS_MAX=5) and the default ALARM_LEN.
REQ-029 The four digits SHALL be built from four instances of sub-module bcd_down_digit.
REQ-029a bcd_down_digit parameter: MAX. Ports: clk_cin, rst, en, load, preset[3:0], digit[3:0], borrow.
REQ-029b In bcd_down_digit, borrow = en && digit==0 (combinational); the digit wraps 0->MAX.
REQ-030 The top level SHALL contain the FSM, preset validation, zero detection and the alarm counter.

Verification
REQ-031 Load 01:00 then start, 1 edge in RUN -> min_out=8'h00, sec_out=8'h59.
REQ-032 Load 00:02, start, 2 RUN edges -> 00:00, done=1, alarm high exactly 10 cycles, then start -> IDLE with done=0.
REQ-033 At 05:30 in RUN, assert pause, hold 5 edges -> count stays 05:30; start -> 05:29 one edge after resume.
REQ-034 Load preset_sec=8'h6A from count 12:34 -> load_err single pulse, count stays 12:34, state IDLE.
REQ-035 Same edge load=1, pause=1, start=1 with preset 59:59 during RUN -> IDLE, count 59:59, running=0.
REQ-036 Assert rst asynchronously mid-alarm at count 00:00 -> alarm and done fall without a clock edge; start with 00:00 stays IDLE.
